// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between fetch and data requesters, one outstanding transaction.
// Optional performance counters are built when MEM_ARB_PERF_COUNTERS_EN is defined.
module mem_port_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ready,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fetch_stall,
  output logic                  data_stall,
  output logic [31:0]           perf_fetch_grants,
  output logic [31:0]           perf_data_grants,
  output logic [31:0]           perf_conflict_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_F = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  state_t                state_q, state_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  port_free_s;
  logic                  resp_f_s;
  logic                  resp_d_s;
  logic                  grant_f_s;
  logic                  grant_d_s;

  // Port availability, grant decision, next state and starvation tracking.
  // Every grant and response term is gated by reset so all outputs read 0 while it is low.
  always_comb begin
    port_free_s  = 1'b0;
    resp_f_s     = 1'b0;
    resp_d_s     = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE: begin
        port_free_s = 1'b1;
      end
      BUSY_F: begin
        port_free_s = mem_valid;
        resp_f_s    = reset && mem_valid;
      end
      BUSY_D: begin
        port_free_s = mem_valid;
        resp_d_s    = reset && mem_valid;
      end
      default: begin
        port_free_s = 1'b1;
      end
    endcase

    grant_f_s = reset && port_free_s && fetch_req &&
                ((starve_cnt_q >= STARVE_LIM) || !data_req);
    grant_d_s = reset && port_free_s && data_req && !grant_f_s;

    if (!port_free_s) begin
      state_d = state_q;
    end else if (grant_f_s) begin
      state_d = BUSY_F;
    end else if (grant_d_s) begin
      state_d = BUSY_D;
    end else begin
      state_d = IDLE;
    end

    if (fetch_req && !grant_f_s) begin
      if (starve_cnt_q != 4'hF) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end else begin
      starve_cnt_d = 4'd0;
    end

    if (resp_f_s) begin
      fetch_data_d = mem_rdata;
    end else begin
      fetch_data_d = fetch_data_q;
    end

    if (resp_d_s) begin
      data_rdata_d = mem_rdata;
    end else begin
      data_rdata_d = data_rdata_q;
    end
  end

  // Requester and memory-side outputs; responses bypass the hold register in their own cycle.
  always_comb begin
    fetch_ready = grant_f_s;
    data_ready  = grant_d_s;
    mem_req     = grant_f_s || grant_d_s;
    if (grant_f_s) begin
      mem_we    = 1'b0;
      mem_addr  = fetch_addr;
      mem_wdata = '0;
    end else if (grant_d_s) begin
      mem_we    = data_we;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
    fetch_valid = resp_f_s;
    data_valid  = resp_d_s;
    fetch_data  = fetch_data_d;
    data_rdata  = data_rdata_d;
    fetch_stall = reset && fetch_req && !grant_f_s;
    data_stall  = reset && data_req && !resp_d_s;
  end

  // State, starvation counter and response hold registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
    end
  end

`ifdef MEM_ARB_PERF_COUNTERS_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_data_q, perf_data_d;
  logic [31:0] perf_conf_q, perf_conf_d;
  logic        conflict_s;

  // Wrapping event counters for grants and contended free cycles.
  always_comb begin
    conflict_s = reset && port_free_s && fetch_req && data_req;
    if (grant_f_s) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end else begin
      perf_fetch_d = perf_fetch_q;
    end
    if (grant_d_s) begin
      perf_data_d = perf_data_q + 32'd1;
    end else begin
      perf_data_d = perf_data_q;
    end
    if (conflict_s) begin
      perf_conf_d = perf_conf_q + 32'd1;
    end else begin
      perf_conf_d = perf_conf_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetch_q <= 32'd0;
      perf_data_q  <= 32'd0;
      perf_conf_q  <= 32'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_data_q  <= perf_data_d;
      perf_conf_q  <= perf_conf_d;
    end
  end

  assign perf_fetch_grants    = perf_fetch_q;
  assign perf_data_grants     = perf_data_q;
  assign perf_conflict_cycles = perf_conf_q;
`else
  assign perf_fetch_grants    = 32'd0;
  assign perf_data_grants     = 32'd0;
  assign perf_conflict_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter; memory responses are driven cycle by cycle.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready, fetch_valid;
  logic [31:0] fetch_data;
  logic        data_req, data_we;
  logic [31:0] data_addr, data_wdata;
  logic        data_ready, data_valid;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        fetch_stall, data_stall;
  logic [31:0] perf_fetch_grants, perf_data_grants, perf_conflict_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_valid(data_valid), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .fetch_stall(fetch_stall), .data_stall(data_stall),
    .perf_fetch_grants(perf_fetch_grants), .perf_data_grants(perf_data_grants),
    .perf_conflict_cycles(perf_conflict_cycles)
  );

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_valid;
    logic [31:0] m_rdata;
    logic        e_fr;
    logic        e_dr;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwd;
    logic        e_fv;
    logic        e_dv;
    logic [31:0] e_fd;
    logic [31:0] e_dd;
    logic        e_fst;
    logic        e_dst;
  } vec_t;

  vec_t vecs [0:14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag,
                            input logic e_fr, input logic e_dr, input logic e_mreq, input logic e_mwe,
                            input logic [31:0] e_maddr, input logic [31:0] e_mwd,
                            input logic e_fv, input logic e_dv,
                            input logic [31:0] e_fd, input logic [31:0] e_dd,
                            input logic e_fst, input logic e_dst);
    chk({tag, ".fetch_ready"}, {31'd0, fetch_ready}, {31'd0, e_fr});
    chk({tag, ".data_ready"},  {31'd0, data_ready},  {31'd0, e_dr});
    chk({tag, ".mem_req"},     {31'd0, mem_req},     {31'd0, e_mreq});
    chk({tag, ".mem_we"},      {31'd0, mem_we},      {31'd0, e_mwe});
    chk({tag, ".mem_addr"},    mem_addr,  e_maddr);
    chk({tag, ".mem_wdata"},   mem_wdata, e_mwd);
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
    chk({tag, ".data_valid"},  {31'd0, data_valid},  {31'd0, e_dv});
    chk({tag, ".fetch_data"},  fetch_data, e_fd);
    chk({tag, ".data_rdata"},  data_rdata, e_dd);
    chk({tag, ".fetch_stall"}, {31'd0, fetch_stall}, {31'd0, e_fst});
    chk({tag, ".data_stall"},  {31'd0, data_stall},  {31'd0, e_dst});
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic dr, input logic we,
                       input logic [31:0] da, input logic [31:0] wd, input logic mv, input logic [31:0] mr);
    fetch_req  = fr;
    fetch_addr = fa;
    data_req   = dr;
    data_we    = we;
    data_addr  = da;
    data_wdata = wd;
    mem_valid  = mv;
    mem_rdata  = mr;
  endtask

  initial begin
    logic        win_f, prev_f, exp_fv, exp_dv;
    logic [31:0] fd_exp, dd_exp;
    logic [31:0] base_f, base_d, base_c;

    //          f_req f_addr    d_req we   d_addr    d_wdata        mv   m_rdata        fr   dr   mreq mwe  maddr     mwd            fv   dv   fd             dd             fst  dst
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0,        1'b1,1'b0,1'b1,1'b0,32'h100, 32'h0,         1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0};
    vecs[1]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,   32'h0,         1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 32'h11111111, 1'b0,1'b0,1'b0,1'b0,32'h0,   32'h0,         1'b1,1'b0,32'h11111111, 32'h0,        1'b0,1'b0};
    vecs[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 32'hDEADBEEF,  1'b0, 32'h0,        1'b0,1'b1,1'b1,1'b1,32'h300, 32'hDEADBEEF,  1'b0,1'b0,32'h11111111, 32'h0,        1'b0,1'b1};
    vecs[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 32'hCAFEF00D, 1'b0,1'b0,1'b0,1'b0,32'h0,   32'h0,         1'b0,1'b1,32'h11111111, 32'hCAFEF00D, 1'b0,1'b0};
    vecs[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h200, 32'h0,         1'b0, 32'h0,        1'b0,1'b1,1'b1,1'b0,32'h200, 32'h0,         1'b0,1'b0,32'h11111111, 32'hCAFEF00D, 1'b0,1'b1};
    vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h204, 32'h0,         1'b1, 32'hA0000200, 1'b0,1'b1,1'b1,1'b0,32'h204, 32'h0,         1'b0,1'b1,32'h11111111, 32'hA0000200, 1'b0,1'b0};
    vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h208, 32'h0,         1'b1, 32'hA0000204, 1'b0,1'b1,1'b1,1'b0,32'h208, 32'h0,         1'b0,1'b1,32'h11111111, 32'hA0000204, 1'b0,1'b0};
    vecs[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 32'hA0000208, 1'b0,1'b0,1'b0,1'b0,32'h0,   32'h0,         1'b0,1'b1,32'h11111111, 32'hA0000208, 1'b0,1'b0};
    vecs[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 32'h55555555, 1'b0,1'b0,1'b0,1'b0,32'h0,   32'h0,         1'b0,1'b0,32'h11111111, 32'hA0000208, 1'b0,1'b0};
    vecs[10] = '{1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'h0,         1'b0, 32'h0,        1'b0,1'b1,1'b1,1'b0,32'h500, 32'h0,         1'b0,1'b0,32'h11111111, 32'hA0000208, 1'b1,1'b1};
    vecs[11] = '{1'b1, 32'h400, 1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 32'h77777777, 1'b1,1'b0,1'b1,1'b0,32'h400, 32'h0,         1'b0,1'b1,32'h11111111, 32'h77777777, 1'b0,1'b0};
    vecs[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h504, 32'h12345678,  1'b1, 32'h88888888, 1'b0,1'b1,1'b1,1'b1,32'h504, 32'h12345678,  1'b1,1'b0,32'h88888888, 32'h77777777, 1'b0,1'b1};
    vecs[13] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         1'b1, 32'h99999999, 1'b0,1'b0,1'b0,1'b0,32'h0,   32'h0,         1'b0,1'b1,32'h88888888, 32'h99999999, 1'b0,1'b0};
    vecs[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,   32'h0,         1'b0,1'b0,32'h88888888, 32'h99999999, 1'b0,1'b0};

    // Reset held with requests pending: everything must read 0.
    reset = 1'b0;
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h300, 32'hFFFFFFFF, 1'b1, 32'h12121212);
    repeat (2) @(posedge clock);
    #2;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("reset.perf_fetch", perf_fetch_grants, 32'h0);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].f_req, vecs[i].f_addr, vecs[i].d_req, vecs[i].d_we,
            vecs[i].d_addr, vecs[i].d_wdata, vecs[i].m_valid, vecs[i].m_rdata);
      #4;
      check_outs($sformatf("vec%0d", i), vecs[i].e_fr, vecs[i].e_dr, vecs[i].e_mreq, vecs[i].e_mwe,
                 vecs[i].e_maddr, vecs[i].e_mwd, vecs[i].e_fv, vecs[i].e_dv,
                 vecs[i].e_fd, vecs[i].e_dd, vecs[i].e_fst, vecs[i].e_dst);
      @(posedge clock);
      #2;
    end

    // Reset pulsed while a load is outstanding, then a stray response.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h800, 32'h0, 1'b0, 32'h0);
    #4;
    check_outs("rst_grant", 1'b0, 1'b1, 1'b1, 1'b0, 32'h800, 32'h0, 1'b0, 1'b0,
               32'h88888888, 32'h99999999, 1'b0, 1'b1);
    @(posedge clock);
    #2;
    drive(1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hEEEEEEEE);
    reset = 1'b0;
    #2;
    check_outs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    reset = 1'b1;
    @(posedge clock);
    #2;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBBBBBBBB);
    #4;
    check_outs("stray", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    drive(1'b1, 32'h900, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #4;
    check_outs("post_rst_fetch", 1'b1, 1'b0, 1'b1, 1'b0, 32'h900, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h13572468);
    #4;
    check_outs("post_rst_resp", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h13572468, 32'h0, 1'b0, 1'b0);
    base_f = perf_fetch_grants;
    base_d = perf_data_grants;
    base_c = perf_conflict_cycles;
    @(posedge clock);
    #2;

    // Both requesters held with a 1-cycle memory: four data grants, then one fetch grant.
    fd_exp = 32'h13572468;
    dd_exp = 32'h0;
    prev_f = 1'b0;
    for (int k = 0; k < 10; k++) begin
      win_f  = ((k % 5) == 4);
      exp_fv = (k > 0) && prev_f;
      exp_dv = (k > 0) && !prev_f;
      if (exp_fv) fd_exp = 32'hF0000000 | 32'(k);
      if (exp_dv) dd_exp = 32'hF0000000 | 32'(k);
      drive(1'b1, 32'h600, 1'b1, 1'b0, 32'h700, 32'h0, (k > 0), 32'hF0000000 | 32'(k));
      #4;
      check_outs($sformatf("starve%0d", k), win_f, !win_f, 1'b1, 1'b0,
                 win_f ? 32'h600 : 32'h700, 32'h0, exp_fv, exp_dv, fd_exp, dd_exp, !win_f, !exp_dv);
      prev_f = win_f;
      @(posedge clock);
      #2;
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hF000000A);
    #4;
    check_outs("starve_tail", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hF000000A, dd_exp, 1'b0, 1'b0);
`ifdef MEM_ARB_PERF_COUNTERS_EN
    chk("perf_fetch_grants",    perf_fetch_grants - base_f,    32'd2);
    chk("perf_data_grants",     perf_data_grants - base_d,     32'd8);
    chk("perf_conflict_cycles", perf_conflict_cycles - base_c, 32'd10);
`else
    chk("perf_fetch_grants",    perf_fetch_grants | base_f,    32'd0);
    chk("perf_data_grants",     perf_data_grants | base_d,     32'd0);
    chk("perf_conflict_cycles", perf_conflict_cycles | base_c, 32'd0);
`endif
    @(posedge clock);
    #2;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
